pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage core: the generic successor to the fixed-field EX/MEM latch.
- Carries one opaque payload bus (packed wd/wreg/wdata/opcode/func3/mem_addr/reg2 or any other stage's fields) with valid/ready flow control instead of a global stall vector.
- Optional 2-entry skid buffer breaks the combinational ready path.
- Flush inserts a NOP bubble; a saturating counter reports bubbles seen downstream.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- PAYLOAD_W, 143, width of the packed stage payload (default = EX/MEM field set: 5+1+32+7+3+32+32+... packed by the instantiating stage).
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- NOP_PAYLOAD, all-zero, payload value driven when no valid entry is held (NOP reg addr, write disable, zero data).
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  in  1  stage clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries (branch mispredict / exception).
- in_valid  in  1  upstream stage presents a payload.
- in_ready  out  1  this stage accepts the payload this cycle.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  head entry valid toward the downstream stage.
- out_ready  in  1  downstream accepts the head entry this cycle.
- out_data  out  PAYLOAD_W  head payload; NOP_PAYLOAD when out_valid=0.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID_EN=0).
- bubble_cnt  out  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0.

Behaviour:
- Reset (rst=0, async):
  - All entries invalid; out_valid=0, out_data=NOP_PAYLOAD, occupancy=0, bubble_cnt=0.
  - in_ready=0 while rst is low; in_ready=1 from the first edge after release.
- Handshakes: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready. Both may occur in the same cycle.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On input transfer: the main register loads in_data and out_valid=1 next cycle.
  - On output transfer with no input transfer: out_valid=0 and out_data=NOP_PAYLOAD next cycle.
  - Latency 1 cycle.
- SKID_EN=1 state machine on {main_v, skid_v}:
  - EMPTY {0,0}:
    - input transfer -> ONE (main loads in_data).
  - ONE {1,0}:
    - input and output transfer -> ONE (main reloads).
    - input only -> FULL (skid loads in_data).
    - output only -> EMPTY.
  - FULL {1,1}:
    - in_ready=0.
    - output transfer -> ONE (main <= skid, skid cleared to NOP_PAYLOAD).
  - in_ready is a register equal to !skid_v of the next state; no combinational path from out_ready.
  - Latency 1 cycle; throughput 1 per cycle under continuous out_ready.
  - Order is strictly FIFO; the skid entry never overtakes main.
- Flush (synchronous, highest priority after reset):
  - Next state EMPTY; all data registers load NOP_PAYLOAD.
  - An input handshake in the flush cycle is discarded. An output handshake in the flush cycle still counts as delivered.
  - in_ready=1 the cycle after a flush.
- out_data is always NOP_PAYLOAD when out_valid=0, so downstream decoding of an invalid slot is harmless (write disable).
- occupancy = main_v + skid_v, registered.
- bubble_cnt:
  - Increments when out_ready=1 and out_valid=0, including flush-induced bubbles.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.

Decomposition:
- Shared package/defines gets:
  - NOP payload constants and the per-stage packed-field offsets (EX_MEM_W etc.).
  - The RstEnable/WriteDisable equivalents re-expressed for active-low reset.
- One natural sub-module, pipe_sat_counter (CNT_W, inc, saturating), reused by other perf counters.

Test Plan:
- Reset then stream: rst low 3 cycles, release; in_valid=1 with payloads 0x1..0x8 and out_ready=1 -> out_data 0x1..0x8 on consecutive cycles starting 1 cycle after acceptance; occupancy stays 1; bubble_cnt=1 (first empty cycle).
- Backpressure (SKID_EN=1): out_ready=0 while feeding A, B, C:
  - A and B are accepted, occupancy=2, in_ready=0, C held.
  - Raising out_ready -> A, B, C emerge in order with no loss or duplicate.
- Simultaneous in/out in ONE state: hold occupancy=1 and toggle both handshakes every cycle for 100 cycles -> occupancy constant 1, in_ready never drops.
- Flush in FULL with in_valid=1 (payload 0xDEAD) -> next cycle out_valid=0, out_data=NOP_PAYLOAD, occupancy=0, 0xDEAD never appears at the output.
- Async reset mid-stream: assert rst between clock edges while FULL -> out_valid=0 and in_ready=0 immediately, without waiting for a clock edge.
- SKID_EN=0 build and saturation (CNT_W=4):
  - in_ready follows out_ready combinationally when full.
  - out_ready=1 with no input for 20 cycles -> bubble_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared definitions for the inter-stage pipeline registers of the 5-stage core:
//   - reset / write-enable polarity constants (reset is active-low)
//   - NOP field values and the packed EX/MEM payload layout
//   - FSM state encoding for the stage register ({main_v, skid_v})
//   - small helpers (occupancy from state, EX/MEM payload packing)
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    // Reset is asserted when rst equals RST_ENABLE (active-low).
    localparam logic RST_ENABLE    = 1'b0;
    localparam logic RST_DISABLE   = 1'b1;
    // Register-file write enable carried in the payload: 0 means "do not write".
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;

    // NOP field values: register x0, write disabled, zero data.
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
    localparam logic [31:0] ZERO_WORD    = 32'd0;

    // EX/MEM field widths.
    localparam int EXM_WD_W       = 5;
    localparam int EXM_WREG_W     = 1;
    localparam int EXM_WDATA_W    = 32;
    localparam int EXM_OPCODE_W   = 7;
    localparam int EXM_FUNC3_W    = 3;
    localparam int EXM_MEM_ADDR_W = 32;
    localparam int EXM_REG2_W     = 32;
    // Stage-specific extension bits packed above the named fields.
    localparam int EXM_EXT_W      = 31;

    // EX/MEM field offsets, LSB first.
    localparam int EXM_REG2_LSB     = 0;
    localparam int EXM_MEM_ADDR_LSB = EXM_REG2_LSB + EXM_REG2_W;
    localparam int EXM_FUNC3_LSB    = EXM_MEM_ADDR_LSB + EXM_MEM_ADDR_W;
    localparam int EXM_OPCODE_LSB   = EXM_FUNC3_LSB + EXM_FUNC3_W;
    localparam int EXM_WDATA_LSB    = EXM_OPCODE_LSB + EXM_OPCODE_W;
    localparam int EXM_WREG_LSB     = EXM_WDATA_LSB + EXM_WDATA_W;
    localparam int EXM_WD_LSB       = EXM_WREG_LSB + EXM_WREG_W;
    localparam int EXM_EXT_LSB      = EXM_WD_LSB + EXM_WD_W;
    localparam int EX_MEM_W         = EXM_EXT_LSB + EXM_EXT_W;   // 143

    // IF/ID carries pc + instruction word.
    localparam int IF_ID_W = 64;

    // All-zero payload decodes as NOP: rd=x0, write disabled, zero data.
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;

    // Stage register state, encoded directly as {main_v, skid_v}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_e;

    function automatic logic [1:0] occ_of(input stage_state_e s);
        logic [1:0] b;
        b = s;
        return {1'b0, b[1]} + {1'b0, b[0]};
    endfunction

    function automatic logic [EX_MEM_W-1:0] pack_ex_mem(
        input logic [EXM_EXT_W-1:0]      ext,
        input logic [EXM_WD_W-1:0]       wd,
        input logic                      wreg,
        input logic [EXM_WDATA_W-1:0]    wdata,
        input logic [EXM_OPCODE_W-1:0]   opcode,
        input logic [EXM_FUNC3_W-1:0]    func3,
        input logic [EXM_MEM_ADDR_W-1:0] mem_addr,
        input logic [EXM_REG2_W-1:0]     reg2
    );
        return {ext, wd, wreg, wdata, opcode, func3, mem_addr, reg2};
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Saturating up-counter for performance events. Holds at all-ones instead of
// wrapping; cleared only by reset.
// Ports:
//   clk    in           clock, rising edge
//   rst    in           asynchronous active-low reset
//   inc    in           count one event this cycle
//   count  out [CNT_W]  current count
// -----------------------------------------------------------------------------
module pipe_sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            count_q <= '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_ONE;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic valid/ready pipeline register placed between IF/ID, ID/EX, EX/MEM and
// MEM/WB. Carries an opaque packed payload. With SKID_EN=1 a second (skid) entry
// lets in_ready be a flop so no combinational path runs from out_ready to
// in_ready; with SKID_EN=0 it is a single register with combinational in_ready.
// Flush empties the stage and reloads every data register with NOP_PAYLOAD.
// Ports:
//   clk        in               clock, rising edge
//   rst        in               asynchronous active-low reset
//   flush      in               synchronous kill of all held entries
//   in_valid   in               upstream payload present
//   in_ready   out              stage accepts this cycle
//   in_data    in  [PAYLOAD_W]  upstream payload
//   out_valid  out              head entry valid
//   out_ready  in               downstream accepts head entry
//   out_data   out [PAYLOAD_W]  head payload (NOP_PAYLOAD when invalid)
//   occupancy  out [2]          held entries, 0..2
//   bubble_cnt out [CNT_W]      saturating count of out_ready & !out_valid
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                   PAYLOAD_W   = EX_MEM_W,
    parameter bit                   SKID_EN     = 1'b1,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
    parameter int                   CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     bubble_cnt
);

    stage_state_e         state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    // Registered ready: !skid_v of the state being entered. Held low in reset,
    // so it doubles as the "out of reset" qualifier for the SKID_EN=0 path.
    logic                 rdy_q;
    logic                 main_v;
    logic                 in_fire, out_fire;

    assign main_v = state_q[1];

    if (SKID_EN) begin : g_skid
        assign in_ready = rdy_q;
    end else begin : g_noskid
        assign in_ready = rdy_q & (!main_v | out_ready);
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state / data-path. Any transition to EMPTY (or out of the skid)
    // reloads the vacated register with NOP so invalid slots decode as NOP.
    // With SKID_EN=0 an input in ONE implies out_ready, so FULL is unreachable.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_PAYLOAD;
            skid_d  = NOP_PAYLOAD;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    unique case ({in_fire, out_fire})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            state_d = ST_FULL;
                            skid_d  = in_data;
                        end
                        2'b01: begin
                            state_d = ST_EMPTY;
                            main_d  = NOP_PAYLOAD;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_PAYLOAD;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_PAYLOAD;
                    skid_d  = NOP_PAYLOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_PAYLOAD;
            skid_q  <= NOP_PAYLOAD;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= !state_d[0];
        end
    end

    assign out_valid = main_v;
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_ready & !out_valid),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    localparam int PW = 143;
    localparam logic [PW-1:0] NOP  = '0;
    localparam logic [PW-1:0] DEAD = PW'(16'hDEAD);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    // SKID_EN=1, default counter width
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [PW-1:0] in_data = '0, out_data;
    logic [1:0]    occupancy;
    logic [15:0]   bubble_cnt;

    // SKID_EN=0, 4-bit counter
    logic          in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0;
    logic [PW-1:0] in_data0 = '0, out_data0;
    logic [1:0]    occupancy0;
    logic [3:0]    bubble_cnt0;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic saw_dead = 1'b0;
    logic [PW-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.PAYLOAD_W(PW), .SKID_EN(1'b1), .NOP_PAYLOAD(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt));

    pipe_stage_reg #(.PAYLOAD_W(PW), .SKID_EN(1'b0), .NOP_PAYLOAD(NOP), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occupancy0), .bubble_cnt(bubble_cnt0));

    // Scoreboard: inputs are stable from posedge+1, so the handshakes that the
    // next rising edge will see are evaluated on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                chk_cnt++;
                if (sb.size() == 0)
                    $display("FAIL sb_order: got %0h with nothing expected", out_data);
                else begin
                    logic [PW-1:0] e;
                    e = sb.pop_front();
                    if (out_data !== e) $display("FAIL sb_order: got %0h expected %0h", out_data, e);
                    else pass_cnt++;
                end
            end
            if (in_valid && in_ready && !flush) sb.push_back(in_data);
            if (out_data == DEAD) saw_dead = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b expected 0", in_ready); else pass_cnt++;
        chk_cnt++; if (in_ready0 !== 1'b0) $display("FAIL rst_in_ready0: got %0b expected 0", in_ready0); else pass_cnt++;
        chk_cnt++; if (out_data !== NOP) $display("FAIL rst_out_data: got %0h expected %0h", out_data, NOP); else pass_cnt++;
        chk_cnt++; if (occupancy !== 2'd0) $display("FAIL rst_occ: got %0d expected 0", occupancy); else pass_cnt++;
        chk_cnt++; if (bubble_cnt !== 16'd0) $display("FAIL rst_bubble: got %0d expected 0", bubble_cnt); else pass_cnt++;
        rst = 1'b1;
        tick();
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_rel_in_ready: got %0b expected 1", in_ready); else pass_cnt++;
        chk_cnt++; if (in_ready0 !== 1'b1) $display("FAIL rst_rel_in_ready0: got %0b expected 1", in_ready0); else pass_cnt++;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            in_data = PW'(i); in_valid = 1'b1; out_ready = 1'b1;
            tick();
            chk_cnt++; if (out_data !== PW'(i)) $display("FAIL stream_data: got %0h expected %0h", out_data, i); else pass_cnt++;
            chk_cnt++; if (occupancy !== 2'd1) $display("FAIL stream_occ: got %0d expected 1", occupancy); else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %0b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (bubble_cnt !== 16'd1) $display("FAIL stream_bubble: got %0d expected 1", bubble_cnt); else pass_cnt++;
        chk_cnt++; if (sb.size() != 0) $display("FAIL stream_sb_left: got %0d expected 0", sb.size()); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = PW'(16'hA); tick();
        in_data = PW'(16'hB); tick();
        chk_cnt++; if (occupancy !== 2'd2) $display("FAIL bp_occ_full: got %0d expected 2", occupancy); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b expected 0", in_ready); else pass_cnt++;
        in_data = PW'(16'hC); tick();
        chk_cnt++; if (occupancy !== 2'd2) $display("FAIL bp_occ_hold: got %0d expected 2", occupancy); else pass_cnt++;
        chk_cnt++; if (out_data !== PW'(16'hA)) $display("FAIL bp_head: got %0h expected a", out_data); else pass_cnt++;
        out_ready = 1'b1; tick();
        chk_cnt++; if (out_data !== PW'(16'hB)) $display("FAIL bp_second: got %0h expected b", out_data); else pass_cnt++;
        tick();
        chk_cnt++; if (out_data !== PW'(16'hC)) $display("FAIL bp_third: got %0h expected c", out_data); else pass_cnt++;
        in_valid = 1'b0; tick();
        out_ready = 1'b0;
        chk_cnt++; if (occupancy !== 2'd0) $display("FAIL bp_occ_end: got %0d expected 0", occupancy); else pass_cnt++;
        chk_cnt++; if (sb.size() != 0) $display("FAIL bp_sb_left: got %0d expected 0", sb.size()); else pass_cnt++;
        chk_cnt++; if (bubble_cnt !== 16'd1) $display("FAIL bp_bubble: got %0d expected 1", bubble_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bad_occ = 0, bad_rdy = 0;
        in_valid = 1'b1; in_data = PW'(16'h100); out_ready = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            in_data = PW'(16'h200 + i); out_ready = 1'b1;
            tick();
            if (occupancy !== 2'd1) bad_occ++;
            if (in_ready !== 1'b1) bad_rdy++;
        end
        chk_cnt++; if (bad_occ != 0) $display("FAIL b2b_occ: got %0d bad cycles expected 0", bad_occ); else pass_cnt++;
        chk_cnt++; if (bad_rdy != 0) $display("FAIL b2b_in_ready: got %0d bad cycles expected 0", bad_rdy); else pass_cnt++;
        in_valid = 1'b0; tick();
        out_ready = 1'b0;
        chk_cnt++; if (sb.size() != 0) $display("FAIL b2b_sb_left: got %0d expected 0", sb.size()); else pass_cnt++;
        chk_cnt++; if (bubble_cnt !== 16'd1) $display("FAIL b2b_bubble: got %0d expected 1", bubble_cnt); else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = PW'(16'h31); tick();
        in_data = PW'(16'h32); tick();
        chk_cnt++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d expected 2", occupancy); else pass_cnt++;
        in_data = DEAD; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_data !== NOP) $display("FAIL flush_out_data: got %0h expected %0h", out_data, NOP); else pass_cnt++;
        chk_cnt++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d expected 0", occupancy); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %0b expected 1", in_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_stay_empty: got %0b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (saw_dead !== 1'b0) $display("FAIL flush_dead_seen: got %0b expected 0", saw_dead); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = PW'(16'h41); tick();
        in_data = PW'(16'h42); tick();
        in_valid = 1'b0;
        chk_cnt++; if (occupancy !== 2'd2) $display("FAIL arst_pre_occ: got %0d expected 2", occupancy); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL arst_in_ready: got %0b expected 0", in_ready); else pass_cnt++;
        chk_cnt++; if (in_ready0 !== 1'b0) $display("FAIL arst_in_ready0: got %0b expected 0", in_ready0); else pass_cnt++;
        chk_cnt++; if (occupancy !== 2'd0) $display("FAIL arst_occ: got %0d expected 0", occupancy); else pass_cnt++;
        chk_cnt++; if (out_data !== NOP) $display("FAIL arst_out_data: got %0h expected %0h", out_data, NOP); else pass_cnt++;
        chk_cnt++; if (bubble_cnt !== 16'd0) $display("FAIL arst_bubble: got %0d expected 0", bubble_cnt); else pass_cnt++;
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL arst_rel_in_ready: got %0b expected 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_noskid_saturation();
        in_valid0 = 1'b1; in_data0 = PW'(16'h55); out_ready0 = 1'b0;
        tick();
        in_valid0 = 1'b0;
        chk_cnt++; if (out_data0 !== PW'(16'h55)) $display("FAIL ns_data: got %0h expected 55", out_data0); else pass_cnt++;
        chk_cnt++; if (occupancy0 !== 2'd1) $display("FAIL ns_occ: got %0d expected 1", occupancy0); else pass_cnt++;
        chk_cnt++; if (in_ready0 !== 1'b0) $display("FAIL ns_rdy_full: got %0b expected 0", in_ready0); else pass_cnt++;
        out_ready0 = 1'b1; #1;
        chk_cnt++; if (in_ready0 !== 1'b1) $display("FAIL ns_rdy_follow_hi: got %0b expected 1", in_ready0); else pass_cnt++;
        out_ready0 = 1'b0; #1;
        chk_cnt++; if (in_ready0 !== 1'b0) $display("FAIL ns_rdy_follow_lo: got %0b expected 0", in_ready0); else pass_cnt++;
        out_ready0 = 1'b1;
        tick();
        chk_cnt++; if (out_valid0 !== 1'b0) $display("FAIL ns_drain_valid: got %0b expected 0", out_valid0); else pass_cnt++;
        chk_cnt++; if (out_data0 !== NOP) $display("FAIL ns_drain_data: got %0h expected %0h", out_data0, NOP); else pass_cnt++;
        chk_cnt++; if (bubble_cnt0 !== 4'd0) $display("FAIL ns_bubble0: got %0d expected 0", bubble_cnt0); else pass_cnt++;
        repeat (14) tick();
        chk_cnt++; if (bubble_cnt0 !== 4'd14) $display("FAIL ns_bubble14: got %0d expected 14", bubble_cnt0); else pass_cnt++;
        repeat (6) tick();
        out_ready0 = 1'b0;
        chk_cnt++; if (bubble_cnt0 !== 4'd15) $display("FAIL ns_bubble_sat: got %0d expected 15", bubble_cnt0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_noskid_saturation();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
